// File: rtl/uart_cmd_sched.sv
// Round-robin scheduler sharing one UART byte tx/rx pair between NUM_REQ command sources.
// Each 16-bit command goes out high byte first; reads wait for one response byte or time out.
module uart_cmd_sched #(
  parameter int NUM_REQ    = 4,
  parameter int CMD_WIDTH  = 16,
  parameter int READ_WIDTH = 8,
  parameter int TIMEOUT    = 65535
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]   req_cmd,
  input  logic [NUM_REQ-1:0]             req_vld,
  output logic [NUM_REQ-1:0]             req_rdy,
  output logic [7:0]                     tx_data,
  output logic                           tx_vld,
  input  logic                           tx_rdy,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_vld,
  output logic                           rsp_vld,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  output logic [READ_WIDTH-1:0]          rsp_data,
  output logic                           rsp_err,
  output logic                           busy
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO, WAIT_RSP} state_t;

  state_t                 state, state_nxt;
  logic [CMD_WIDTH-1:0]   cmd, gnt_cmd;
  logic [ID_W-1:0]        id, rr_ptr, gnt_id, rr_nxt;
  logic                   gnt_found, accept, terminal;
  logic [CNT_W-1:0]       cnt;

  // Search starts at rr_ptr so the last winner drops to lowest priority.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt_cmd   = '0;
    rr_nxt    = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_found && req_vld[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
        gnt_cmd   = req_cmd[idx*CMD_WIDTH +: CMD_WIDTH];
        rr_nxt    = ID_W'((idx + 1) % NUM_REQ);
      end
    end
  end

  assign terminal = (cnt == CNT_W'(TIMEOUT - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    req_rdy   = '0;
    accept    = 1'b0;
    case (state)
      IDLE:     if (gnt_found && !rst) begin
                  req_rdy[gnt_id] = 1'b1;
                  accept          = 1'b1;
                  state_nxt       = SEND_HI;
                end
      SEND_HI:  if (tx_rdy) state_nxt = SEND_LO;
      SEND_LO:  if (tx_rdy) state_nxt = cmd[CMD_WIDTH-1] ? WAIT_RSP : IDLE;
      WAIT_RSP: if (rx_vld || terminal) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cmd      <= '0;
      id       <= '0;
      cnt      <= '0;
      tx_vld   <= 1'b0;
      tx_data  <= '0;
      rsp_vld  <= 1'b0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rsp_vld <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          cmd     <= gnt_cmd;
          id      <= gnt_id;
          rr_ptr  <= rr_nxt;
          tx_vld  <= 1'b1;
          tx_data <= gnt_cmd[CMD_WIDTH-1 -: 8];
        end
        SEND_HI: if (tx_rdy) tx_data <= cmd[7:0];
        SEND_LO: if (tx_rdy) begin
          tx_vld <= 1'b0;
          cnt    <= '0;
          if (!cmd[CMD_WIDTH-1]) begin
            rsp_vld  <= 1'b1;
            rsp_id   <= id;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
          end
        end
        WAIT_RSP: begin
          cnt <= cnt + 1'b1;
          // A byte arriving on the terminal count still counts as a good response.
          if (rx_vld) begin
            rsp_vld  <= 1'b1;
            rsp_id   <= id;
            rsp_data <= READ_WIDTH'(rx_data);
            rsp_err  <= 1'b0;
          end else if (terminal) begin
            rsp_vld  <= 1'b1;
            rsp_id   <= id;
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_sched.sv
// Directed bench for uart_cmd_sched: table of write grants plus hand sequences for stalls,
// reads, timeout, terminal-cycle data and reset abort.
module tb_uart_cmd_sched;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*16-1:0] req_cmd;
  logic [NR-1:0]   req_vld, req_rdy;
  logic [7:0]      tx_data, rx_data;
  logic            tx_vld, tx_rdy, rx_vld;
  logic            rsp_vld, rsp_err, busy;
  logic [1:0]      rsp_id;
  logic [7:0]      rsp_data;

  logic [15:0] cmds [NR];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_cmd = '0;
    for (int i = 0; i < NR; i++) req_cmd[i*16 +: 16] = cmds[i];
  end

  uart_cmd_sched #(.NUM_REQ(NR), .CMD_WIDTH(16), .READ_WIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_cmd(req_cmd), .req_vld(req_vld), .req_rdy(req_rdy),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .rx_data(rx_data), .rx_vld(rx_vld),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [NR-1:0] vld;
    int            gnt;
  } vec_t;

  vec_t tbl [9];

  // Write transaction with tx_rdy=1; starts and ends at a negedge with state IDLE.
  task automatic do_write(input vec_t v);
    logic [15:0] c;
    c = cmds[v.gnt];
    req_vld = v.vld;
    #1 chk("grant", 32'(req_rdy), 32'(4'b0001 << v.gnt));
    @(negedge clk);
    chk("hi_vld", 32'(tx_vld), 1);
    chk("hi_byte", 32'(tx_data), 32'(c[15:8]));
    chk("rdy_gone", 32'(req_rdy), 0);
    @(negedge clk);
    chk("lo_byte", 32'(tx_data), 32'(c[7:0]));
    chk("no_early_rsp", 32'(rsp_vld), 0);
    @(negedge clk);
    chk("wr_rsp", {rsp_vld, rsp_err, 6'(rsp_id), rsp_data}, {1'b1, 1'b0, 6'(v.gnt), 8'h00});
  endtask

  initial begin
    cmds[0] = 16'h1234; cmds[1] = 16'h2101; cmds[2] = 16'h4202; cmds[3] = 16'h7303;
    tbl[0] = '{4'b0001, 0}; tbl[1] = '{4'b1111, 1}; tbl[2] = '{4'b1111, 2};
    tbl[3] = '{4'b1111, 3}; tbl[4] = '{4'b1111, 0}; tbl[5] = '{4'b1111, 1};
    tbl[6] = '{4'b0001, 0}; tbl[7] = '{4'b1010, 1}; tbl[8] = '{4'b1010, 3};

    rst = 1'b1; req_vld = 4'b1111; tx_rdy = 1'b1; rx_vld = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {tx_vld, rsp_vld, rsp_err, busy, 4'(req_rdy)}, 8'h00);
    chk("rst_data", {tx_data, 6'(rsp_id), rsp_data}, 0);
    req_vld = '0; rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) do_write(tbl[i]);
    // rr_ptr now 0

    // tx_rdy stall in SEND_HI
    req_vld = 4'b0100; tx_rdy = 1'b0;
    #1 chk("stall_grant", 32'(req_rdy), 32'h4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_hold", {tx_vld, tx_data}, {1'b1, 8'h42});
    end
    tx_rdy = 1'b1; req_vld = '0;
    @(negedge clk);
    chk("stall_lo", {tx_vld, tx_data}, {1'b1, 8'h02});
    @(negedge clk);
    chk("stall_rsp", {rsp_vld, 6'(rsp_id)}, {1'b1, 6'd2});
    // rr_ptr now 3

    // Read from requester 2 with stray rx during SEND_HI
    cmds[2] = 16'h8005;
    req_vld = 4'b0100;
    #1 chk("rd_grant", 32'(req_rdy), 32'h4);
    @(negedge clk);
    chk("rd_hi", 32'(tx_data), 32'h80);
    req_vld = '0; rx_vld = 1'b1; rx_data = 8'h77;
    @(negedge clk);
    rx_vld = 1'b0;
    chk("rd_lo", {rsp_vld, tx_data}, {1'b0, 8'h05});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rd_wait", {rsp_vld, busy, tx_vld}, 3'b010);
    end
    rx_vld = 1'b1; rx_data = 8'hA5;
    @(negedge clk);
    rx_vld = 1'b0;
    chk("rd_rsp", {rsp_vld, rsp_err, 6'(rsp_id), rsp_data, busy}, {1'b1, 1'b0, 6'd2, 8'hA5, 1'b0});
    // rr_ptr now 3

    // Timeout on requester 3
    cmds[3] = 16'h8103;
    req_vld = 4'b1000;
    #1 chk("to_grant", 32'(req_rdy), 32'h8);
    @(negedge clk); req_vld = '0;
    @(negedge clk);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk("to_pulse", 32'(rsp_vld), 32'(k == 17));
    end
    chk("to_rsp", {rsp_err, 6'(rsp_id), rsp_data}, {1'b1, 6'd3, 8'h00});
    // rr_ptr now 0

    // Data on the terminal count wins over the timeout
    cmds[0] = 16'h8234;
    req_vld = 4'b0001;
    #1 chk("term_grant", 32'(req_rdy), 32'h1);
    @(negedge clk); req_vld = '0;
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("term_quiet", 32'(rsp_vld), 0);
    end
    rx_vld = 1'b1; rx_data = 8'h5C;
    @(negedge clk);
    rx_vld = 1'b0;
    chk("term_rsp", {rsp_vld, rsp_err, 6'(rsp_id), rsp_data}, {1'b1, 1'b0, 6'd0, 8'h5C});
    // rr_ptr now 1

    // Reset during WAIT_RSP aborts the read
    cmds[1] = 16'h8111;
    req_vld = 4'b0010;
    #1 chk("abort_grant", 32'(req_rdy), 32'h2);
    @(negedge clk); req_vld = '0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("abort_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_idle", {busy, tx_vld, rsp_vld}, 3'b000);
    rx_vld = 1'b1; rx_data = 8'h99;
    @(negedge clk);
    rx_vld = 1'b0;
    chk("abort_no_rsp", {rsp_vld, busy}, 2'b00);
    @(negedge clk);
    chk("abort_no_rsp2", 32'(rsp_vld), 0);
    req_vld = 4'b1111;
    #1 chk("abort_rr0", 32'(req_rdy), 32'h1);
    @(negedge clk);
    req_vld = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
